// File: rtl/adc_pkg.sv
// adc_pkg: shared FSM state, data width and counter widths for the serial ADC reader.
package adc_pkg;
  typedef enum logic [2:0] {IDLE, CONVERT, SHIFT, DONE, WAIT} adc_state_e;
  localparam int ADC_DATA_BITS = 16;
  localparam int ADC_AVG_SHIFT = 2;
  localparam int TIMER_W = 16;
  localparam int BIT_W = 5;
  localparam int DIV_W = 8;
  localparam int CONV_W = 10;
  localparam int ACC_W = 18;
endpackage

// File: rtl/adc_sclk_divider.sv
// adc_sclk_divider: idle-low serial clock toggling every CLK_DIV cycles while run_i is high.
module adc_sclk_divider
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic sclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);
  logic [DIV_W-1:0] div_q;
  logic sclk_q;
  logic tick;
  // ticks mark the clk edge that flips sclk, so the caller samples in step with it
  assign tick = run_i && (div_q == DIV_W'(CLK_DIV - 1));
  assign rise_tick_o = tick && !sclk_q;
  assign fall_tick_o = tick && sclk_q;
  assign sclk_o = sclk_q;
  always_ff @(posedge clk) begin
    if (rst || !run_i) begin
      div_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + DIV_W'(1);
      sclk_q <= sclk_q ^ tick;
    end
  end
endmodule

// File: rtl/adc_spi_reader.sv
// adc_spi_reader: periodic ADC conversion + 16-bit MSB-first SPI read with one-cycle valid pulse.
// Optional ADC_AVG4_EN: report the truncated mean of every 4 captures instead of each capture.
module adc_spi_reader
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CONV_CYCLES = 40,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int DATA_BITS = ADC_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 adc_sdo,
  output logic                 adc_cnv,
  output logic                 adc_sclk,
  output logic [DATA_BITS-1:0] adc_data,
  output logic                 valid_out,
  output logic                 overrun
);
  localparam logic [TIMER_W-1:0] PER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);
  adc_state_e state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CONV_W-1:0] conv_q, conv_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, cnv_q, cnv_d, ovr_q, ovr_d;
  logic run, rise_tick, fall_tick, capture;
`ifdef ADC_AVG4_EN
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [1:0] phase_q, phase_d;
`endif
  // bit_q[4] means all 16 falling edges are done; stop the divider so sclk stays low
  assign run = (state_q == SHIFT) && !bit_q[4];
  adc_sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk        (clk),
    .rst        (rst),
    .run_i      (run),
    .sclk_o     (adc_sclk),
    .rise_tick_o(rise_tick),
    .fall_tick_o(fall_tick)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = enable ? CONVERT : IDLE;
      CONVERT: state_d = (conv_q == CONV_LAST) ? SHIFT : CONVERT;
      SHIFT:   state_d = bit_q[4] ? DONE : SHIFT;
      DONE:    state_d = (timer_q >= PER_LAST) ? (enable ? CONVERT : IDLE) : WAIT;
      WAIT:    state_d = (timer_q >= PER_LAST) ? (enable ? CONVERT : IDLE) : WAIT;
      default: state_d = IDLE;
    endcase
    capture = (state_q == SHIFT) && bit_q[4];
    timer_d = (state_d == CONVERT && state_q != CONVERT) ? '0 :
              (&timer_q) ? timer_q : timer_q + TIMER_W'(1);
    conv_d = (state_q == CONVERT) ? conv_q + CONV_W'(1) : '0;
    bit_d = (state_q == SHIFT) ? bit_q + BIT_W'(fall_tick) : '0;
    sh_d = rise_tick ? {sh_q[DATA_BITS-2:0], adc_sdo} : sh_q;
    cnv_d = (state_d == CONVERT);
    ovr_d = ovr_q || ((state_d == CONVERT || state_d == SHIFT) && timer_d == PER_LAST);
`ifdef ADC_AVG4_EN
    sum = acc_q + ACC_W'(sh_q);
    acc_d = !enable ? '0 : capture ? ((phase_q == 2'd3) ? '0 : sum) : acc_q;
    phase_d = !enable ? 2'd0 : capture ? phase_q + 2'd1 : phase_q;
    valid_d = capture && (phase_q == 2'd3);
    data_d = valid_d ? DATA_BITS'(sum >> ADC_AVG_SHIFT) : data_q;
`else
    valid_d = capture;
    data_d = capture ? sh_q : data_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      conv_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      cnv_q <= 1'b0;
      ovr_q <= 1'b0;
`ifdef ADC_AVG4_EN
      acc_q <= '0;
      phase_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      conv_q <= conv_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      data_q <= data_d;
      valid_q <= valid_d;
      cnv_q <= cnv_d;
      ovr_q <= ovr_d;
`ifdef ADC_AVG4_EN
      acc_q <= acc_d;
      phase_q <= phase_d;
`endif
    end
  end
  assign adc_cnv = cnv_q;
  assign adc_data = data_q;
  assign valid_out = valid_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: directed checks of conversion timing, serial capture, reset abort, enable drop and overrun.
module tb_adc_spi_reader;
  logic clk = 1'b0;
  logic rst, enable_a, enable_b, sdo_a, sdo_b;
  logic cnv_a, sclk_a, valid_a, ovr_a, cnv_b, sclk_b, valid_b, ovr_b;
  logic [15:0] data_a, data_b;
  int cyc = 0;
  int nvec = 0;
  int nfail = 0;
  logic [15:0] words_a [8];
  logic [15:0] words_b [8];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  adc_spi_reader #(.CLK_DIV(2), .CONV_CYCLES(4), .SAMPLE_PERIOD(100)) dut_a (
    .clk(clk), .rst(rst), .enable(enable_a), .adc_sdo(sdo_a), .adc_cnv(cnv_a),
    .adc_sclk(sclk_a), .adc_data(data_a), .valid_out(valid_a), .overrun(ovr_a)
  );
  adc_spi_reader #(.CLK_DIV(2), .CONV_CYCLES(4), .SAMPLE_PERIOD(50)) dut_b (
    .clk(clk), .rst(rst), .enable(enable_b), .adc_sdo(sdo_b), .adc_cnv(cnv_b),
    .adc_sclk(sclk_b), .adc_data(data_b), .valid_out(valid_b), .overrun(ovr_b)
  );
  // ADC models: latch a new word at each conversion start, shift the next bit after each sclk fall
  logic [15:0] wa = '0, wb = '0;
  int ka = 0, kb = 0, ba = 0, bb = 0;
  always @(posedge cnv_a or negedge sclk_a) begin
    if (cnv_a) begin
      wa = words_a[ka];
      ka = (ka < 7) ? ka + 1 : ka;
      ba = 15;
    end else if (ba > 0) ba = ba - 1;
    sdo_a = wa[ba];
  end
  always @(posedge cnv_b or negedge sclk_b) begin
    if (cnv_b) begin
      wb = words_b[kb];
      kb = (kb < 7) ? kb + 1 : kb;
      bb = 15;
    end else if (bb > 0) bb = bb - 1;
    sdo_b = wb[bb];
  end
  int cnvr_a[$], cnvf_a[$], srise_a[$], vcyc_a[$], cnvr_b[$], srise_b[$], vcyc_b[$];
  logic [15:0] vdat_a[$], vdat_b[$];
  logic pcnv_a = 1'b0, psclk_a = 1'b0, pcnv_b = 1'b0, psclk_b = 1'b0;
  int bad_a = 0, bad_b = 0;
  always @(negedge clk) begin
    if (cnv_a === 1'b1 && !pcnv_a) cnvr_a.push_back(cyc);
    if (cnv_a === 1'b0 && pcnv_a) cnvf_a.push_back(cyc);
    if (sclk_a === 1'b1 && !psclk_a) srise_a.push_back(cyc);
    if (valid_a === 1'b1) begin
      vcyc_a.push_back(cyc);
      vdat_a.push_back(data_a);
    end
    if (cnv_a === 1'b1 && sclk_a === 1'b1) bad_a++;
    if (cnv_b === 1'b1 && !pcnv_b) cnvr_b.push_back(cyc);
    if (sclk_b === 1'b1 && !psclk_b) srise_b.push_back(cyc);
    if (valid_b === 1'b1) begin
      vcyc_b.push_back(cyc);
      vdat_b.push_back(data_b);
    end
    if (cnv_b === 1'b1 && sclk_b === 1'b1) bad_b++;
    pcnv_a = (cnv_a === 1'b1);
    psclk_a = (sclk_a === 1'b1);
    pcnv_b = (cnv_b === 1'b1);
    psclk_b = (sclk_b === 1'b1);
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  task automatic clear_a();
    cnvr_a.delete(); cnvf_a.delete(); srise_a.delete(); vcyc_a.delete(); vdat_a.delete();
  endtask
  int b0, b1, b2, bq;
  initial begin
`ifdef ADC_AVG4_EN
    words_a = '{16'd100, 16'd200, 16'd301, 16'd403, 16'd0, 16'd0, 16'd0, 16'd0};
`else
    words_a = '{16'hA5C3, 16'h0000, 16'hFFFF, 16'h8001, 16'h1234, 16'h5A5A, 16'h3C96, 16'h0000};
`endif
    words_b = '{16'h1357, 16'h2468, 16'hFEDC, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    rst = 1'b1; enable_a = 1'b0; enable_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cnv", 32'(cnv_a), 32'd0);
    check("rst_sclk", 32'(sclk_a), 32'd0);
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_overrun", 32'(ovr_a), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_cnv", 32'(cnv_a), 32'd0);
    clear_a();
    enable_a = 1'b1;
    b0 = cyc + 1;
`ifdef ADC_AVG4_EN
    wait_to(b0 + 300);
    check("avg_no_early_data", 32'(data_a), 32'd0);
    wait_to(b0 + 380);
    enable_a = 1'b0;
    wait_to(b0 + 450);
    check("avg_conv_count", 32'(cnvr_a.size()), 32'd4);
    check("avg_conv3", 32'(cnvr_a[3]), 32'(b0 + 300));
    check("avg_valid_count", 32'(vcyc_a.size()), 32'd1);
    check("avg_valid_cyc", 32'(vcyc_a[0]), 32'(b0 + 369));
    check("avg_data", 32'(vdat_a[0]), 32'd251);
    check("avg_held", 32'(data_a), 32'd251);
`else
    wait_to(b0 + 350);
    enable_a = 1'b0;
    wait_to(b0 + 450);
    check("conv_count", 32'(cnvr_a.size()), 32'd4);
    check("conv0", 32'(cnvr_a[0]), 32'(b0));
    check("conv1", 32'(cnvr_a[1]), 32'(b0 + 100));
    check("conv2", 32'(cnvr_a[2]), 32'(b0 + 200));
    check("conv3", 32'(cnvr_a[3]), 32'(b0 + 300));
    check("cnv_fall", 32'(cnvf_a[0]), 32'(b0 + 4));
    check("sclk_rises", 32'(srise_a.size()), 32'd64);
    check("sclk_first", 32'(srise_a[0]), 32'(b0 + 6));
    check("sclk_16th", 32'(srise_a[15]), 32'(b0 + 66));
    check("valid_count", 32'(vcyc_a.size()), 32'd4);
    check("valid0_cyc", 32'(vcyc_a[0]), 32'(b0 + 69));
    check("valid0_data", 32'(vdat_a[0]), 32'hA5C3);
    check("valid1_cyc", 32'(vcyc_a[1]), 32'(b0 + 169));
    check("valid1_data", 32'(vdat_a[1]), 32'h0000);
    check("valid2_data", 32'(vdat_a[2]), 32'hFFFF);
    check("valid3_cyc", 32'(vcyc_a[3]), 32'(b0 + 369));
    check("valid3_data", 32'(vdat_a[3]), 32'h8001);
    check("cnv_sclk_overlap", 32'(bad_a), 32'd0);
    check("no_overrun", 32'(ovr_a), 32'd0);
    // reset in the middle of a read
    clear_a();
    enable_a = 1'b1;
    b1 = cyc + 1;
    wait_to(b1 + 30);
    check("midshift_sclk", 32'(sclk_a), 32'd1);
    rst = 1'b1;
    wait_to(b1 + 31);
    check("abort_sclk", 32'(sclk_a), 32'd0);
    check("abort_cnv", 32'(cnv_a), 32'd0);
    check("abort_data", 32'(data_a), 32'd0);
    check("abort_valid", 32'(valid_a), 32'd0);
    rst = 1'b0;
    wait_to(b1 + 40);
    enable_a = 1'b0;
    wait_to(b1 + 200);
    check("restart_count", 32'(cnvr_a.size()), 32'd2);
    check("restart_cyc", 32'(cnvr_a[1]), 32'(b1 + 32));
    check("restart_valid_count", 32'(vcyc_a.size()), 32'd1);
    check("restart_valid_cyc", 32'(vcyc_a[0]), 32'(b1 + 101));
    check("restart_data", 32'(vdat_a[0]), 32'h5A5A);
    // enable dropped early in a conversion
    clear_a();
    enable_a = 1'b1;
    b2 = cyc + 1;
    wait_to(b2 + 10);
    enable_a = 1'b0;
    wait_to(b2 + 250);
    check("drop_conv_count", 32'(cnvr_a.size()), 32'd1);
    check("drop_valid_count", 32'(vcyc_a.size()), 32'd1);
    check("drop_valid_cyc", 32'(vcyc_a[0]), 32'(b2 + 69));
    check("drop_data", 32'(vdat_a[0]), 32'h3C96);
    // sample period too short for a full read
    enable_b = 1'b1;
    bq = cyc + 1;
    wait_to(bq + 48);
    check("ovr_before", 32'(ovr_b), 32'd0);
    wait_to(bq + 49);
    check("ovr_set", 32'(ovr_b), 32'd1);
    wait_to(bq + 150);
    enable_b = 1'b0;
    wait_to(bq + 300);
    check("ovr_conv_count", 32'(cnvr_b.size()), 32'd3);
    check("ovr_conv1", 32'(cnvr_b[1]), 32'(bq + 70));
    check("ovr_conv2", 32'(cnvr_b[2]), 32'(bq + 140));
    check("ovr_sclk_rises", 32'(srise_b.size()), 32'd48);
    check("ovr_valid_count", 32'(vcyc_b.size()), 32'd3);
    check("ovr_valid0", 32'(vcyc_b[0]), 32'(bq + 69));
    check("ovr_data0", 32'(vdat_b[0]), 32'h1357);
    check("ovr_valid1", 32'(vcyc_b[1]), 32'(bq + 139));
    check("ovr_data1", 32'(vdat_b[1]), 32'h2468);
    check("ovr_valid2", 32'(vcyc_b[2]), 32'(bq + 209));
    check("ovr_data2", 32'(vdat_b[2]), 32'hFEDC);
    check("ovr_no_overlap", 32'(bad_b), 32'd0);
    check("ovr_sticky", 32'(ovr_b), 32'd1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
Serial ADC front-end that produces the 16-bit `adc_data` / `valid_in` pair consumed by the data processing stage. It consumes nothing from that stage.
- Periodically pulses a conversion-start line.
- Clocks 16 bits out of the ADC MSB-first over an SPI-style link.
- Presents each sample as a one-cycle valid pulse.
- Sole source of samples for the ln(V) pipeline and its FIFO.

Parameters:
- CLK_DIV, 4: `clk` cycles per `adc_sclk` half-period; legal range 1..255.
- CONV_CYCLES, 40: `clk` cycles `adc_cnv` is held high (ADC conversion time); 1..1023.
- SAMPLE_PERIOD, 1000: `clk` cycles between successive conversion starts; must be ≥ CONV_CYCLES + 32*CLK_DIV + 2.
- DATA_BITS, 16: sample width; fixed at 16 in this revision.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = run periodic conversions.
- adc_sdo  in  1  ADC serial data out; ADC updates it after `adc_sclk` falling edge.
- adc_cnv  out  1  conversion start, high during CONVERT.
- adc_sclk  out  1  serial clock, idle low.
- adc_data  out  16  last captured sample, unsigned; held until next capture.
- valid_out  out  1  one-cycle pulse, new `adc_data` valid; drives downstream `valid_in`.
- overrun  out  1  sticky: a period elapsed before the previous read finished.

Behaviour:
- Reset (on any `clk` edge with rst=1, including mid-transfer):
  - `adc_cnv`=0, `adc_sclk`=0, `adc_data`=0, `valid_out`=0, `overrun`=0.
  - FSM goes to IDLE; all counters clear. An aborted transfer produces no `valid_out`.
- FSM states: IDLE, CONVERT, SHIFT, DONE, WAIT.
- IDLE:
  - Outputs low.
  - enable=1 → CONVERT next cycle; that cycle is cycle 0, with `adc_cnv`=1 and the period timer cleared.
- CONVERT:
  - `adc_cnv` is high for exactly CONV_CYCLES cycles (0..CONV_CYCLES-1), then → SHIFT.
- SHIFT:
  - `adc_sclk` toggles every CLK_DIV cycles, starting low.
  - First rising edge at cycle CONV_CYCLES+CLK_DIV.
  - 16 rising edges; `adc_sdo` is registered into the shift register (MSB first) on the same `clk` edge that drives `adc_sclk` 0→1.
  - After the 16th falling edge (cycle CONV_CYCLES+32*CLK_DIV, `adc_sclk`=0) → DONE.
- DONE:
  - Single cycle at CONV_CYCLES+32*CLK_DIV+1.
  - `adc_data` ← shift register and `valid_out`=1 in this cycle.
  - → WAIT.
- WAIT:
  - The period timer counts from cycle 0.
  - At timer = SAMPLE_PERIOD-1: enable=1 → CONVERT (new cycle 0); enable=0 → IDLE.
- Latency, conversion start → `valid_out`: CONV_CYCLES+32*CLK_DIV+1 cycles.
- Throughput: one sample per SAMPLE_PERIOD cycles.
- enable dropped mid-conversion:
  - The current conversion and read complete and `valid_out` still pulses.
  - The FSM then goes to IDLE from WAIT with no further conversion.
- Overrun:
  - If the period timer reaches SAMPLE_PERIOD-1 while the FSM is in CONVERT or SHIFT, `overrun` is set (sticky until rst).
  - The next conversion starts in the cycle after DONE, so conversions never overlap.
- Period timer: 16 bits, saturating. Bit counter: 5 bits. Divider counter: 8 bits.
- `adc_sclk` and `adc_cnv` are registered outputs, glitch-free.

Optional Feature:
Macro ADC_AVG4_EN.
- Defined:
  - A 18-bit accumulator sums 4 consecutive captures.
  - On the 4th DONE, `adc_data` ← sum>>2 (truncating) and `valid_out` pulses; the accumulator then clears.
  - DONE cycles 1–3 produce no pulse.
  - Reset and enable deassertion clear the accumulator and the phase counter.
- Not defined: every DONE updates `adc_data` and pulses `valid_out`, as above.

Decomposition:
- Package adc_pkg:
  - FSM state enum (IDLE, CONVERT, SHIFT, DONE, WAIT).
  - ADC_DATA_BITS=16.
  - ADC_AVG_SHIFT=2.
  - Counter width constants.
- Sub-module adc_sclk_divider:
  - Inputs: `clk`, `rst`, run.
  - Outputs: `adc_sclk`, rise_tick, fall_tick.
  - The top FSM counts rise_tick/fall_tick to sequence the 16 bits.

Test Plan:
1. CLK_DIV=2, CONV_CYCLES=4, SAMPLE_PERIOD=100; ADC model returns 0xA5C3; enable=1 → `adc_cnv` high cycles 0–3, 16 `adc_sclk` pulses, `valid_out` at cycle 69 with `adc_data`=0xA5C3; next `adc_cnv` rise at cycle 100.
2. Model returns 0x0000, then 0xFFFF, then 0x8001 → three pulses 100 cycles apart with exactly those values; `adc_sclk` is low whenever `adc_cnv` is high.
3. rst=1 at cycle 30, mid-SHIFT → next cycle: `adc_sclk`=0, `adc_cnv`=0, `adc_data`=0, no `valid_out`; with enable held, a new conversion starts the cycle after rst falls.
4. enable deasserted at cycle 10 → `valid_out` still at cycle 69 with correct data; no `adc_cnv` afterward.
5. SAMPLE_PERIOD=50 (too short) → `overrun`=1 from cycle 49; conversions are back-to-back (start at cycle 70) with no overlap; every sample is still correct.
6. ADC_AVG4_EN defined; samples 100, 200, 301, 403 → a single `valid_out` with `adc_data`=251, after the 4th capture only.
